// File: rtl/via_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// via_lcd_sequencer
//
// Purpose:
//   Pushes bytes into an HD44780-style character LCD through the VIA
//   interface_adapter register bus. Port B carries the LCD data bus and port A
//   bits 7/6/5 carry E/RW/RS. After reset the sequencer programs both DDRs,
//   parks E/RW/RS low and waits out the LCD power-on time. It then accepts one
//   byte command at a time over a valid/ready handshake. Each command becomes a
//   timed register-write sequence:
//     data byte -> RS setup -> E rise -> E hold -> E fall -> settle wait.
//   The sequencer never reads the LCD busy flag; all timing is count based.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  command can be accepted this cycle
//   cmd_byte   in   8  LCD instruction or character
//   cmd_rs     in   1  0 = instruction, 1 = character data
//   busy       out  1  low only while idle and ready for a command
//   via_cs     out  1  adapter chip_en, one-cycle register write strobe
//   via_rs     out  4  adapter register_select (0=ORB, 1=ORA, 2=DDRB, 3=DDRA)
//   via_data   out  8  adapter data_in
// -----------------------------------------------------------------------------
module via_lcd_sequencer #(
    parameter int E_HOLD_CYCLES     = 4,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int POWERON_CYCLES    = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_rs,
    output logic       busy,
    output logic       via_cs,
    output logic [3:0] via_rs,
    output logic [7:0] via_data
);

    // Counter must hold (longest wait - 1); one spare bit keeps the load safe.
    localparam int MAX_AB   = (E_HOLD_CYCLES > CMD_WAIT_CYCLES) ? E_HOLD_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_CD   = (CLEAR_WAIT_CYCLES > POWERON_CYCLES) ? CLEAR_WAIT_CYCLES : POWERON_CYCLES;
    localparam int MAX_WAIT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(E_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PON_LOAD   = CNT_W'(POWERON_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Adapter register map.
    localparam logic [3:0] REG_ORB  = 4'd0;
    localparam logic [3:0] REG_ORA  = 4'd1;
    localparam logic [3:0] REG_DDRB = 4'd2;
    localparam logic [3:0] REG_DDRA = 4'd3;

    // Port B all outputs; port A only E/RW/RS (bits 7..5) are outputs.
    localparam logic [7:0] DDRB_VALUE = 8'hFF;
    localparam logic [7:0] DDRA_VALUE = 8'hE0;

    // Each state names the register write issued on the clock edge that
    // leaves it, so the write lands on the bus one cycle after the state is
    // entered. The data-byte write of a command is issued directly from IDLE on
    // the accept edge, which puts it on the bus in the cycle after the accept.
    typedef enum logic [3:0] {
        ST_INIT_DDRB,
        ST_INIT_DDRA,
        ST_INIT_CLR,
        ST_POWER_WAIT,
        ST_IDLE,
        ST_SET_CTRL,
        ST_E_HIGH,
        ST_E_HOLD,
        ST_E_LOW,
        ST_WAIT
    } state_t;

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] count_reg,    count_next;
    logic [CNT_W-1:0] wait_reg,     wait_next;
    logic             lcd_rs_reg,   lcd_rs_next;
    logic             via_cs_reg,   via_cs_next;
    logic [3:0]       via_rs_reg,   via_rs_next;
    logic [7:0]       via_data_reg, via_data_next;
    logic             ready_reg,    ready_next;
    logic             busy_reg,     busy_next;
    logic             accept;
    logic             is_clear_cmd;

    // Port A image: E in bit 7, RW (always 0) in bit 6, RS in bit 5.
    function automatic logic [7:0] port_a_ctrl(input logic e, input logic rs);
        return {e, 1'b0, rs, 5'b00000};
    endfunction

    // Clear display (0x01) and return home (0x02) need the long settle time.
    assign is_clear_cmd = !cmd_rs && (cmd_byte <= 8'h02) && (cmd_byte != 8'h00);

    // ready_reg is only ever set while in IDLE, so it alone gates the accept.
    assign accept = (state_reg == ST_IDLE) && cmd_valid && ready_reg;

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        wait_next     = wait_reg;
        lcd_rs_next   = lcd_rs_reg;
        via_cs_next   = 1'b0;
        via_rs_next   = via_rs_reg;
        via_data_next = via_data_reg;
        ready_next    = 1'b0;

        case (state_reg)
            ST_INIT_DDRB: begin
                via_cs_next   = 1'b1;
                via_rs_next   = REG_DDRB;
                via_data_next = DDRB_VALUE;
                state_next    = ST_INIT_DDRA;
            end
            ST_INIT_DDRA: begin
                via_cs_next   = 1'b1;
                via_rs_next   = REG_DDRA;
                via_data_next = DDRA_VALUE;
                state_next    = ST_INIT_CLR;
            end
            ST_INIT_CLR: begin
                // E/RW/RS parked low so an interrupted E pulse is always closed.
                via_cs_next   = 1'b1;
                via_rs_next   = REG_ORA;
                via_data_next = 8'h00;
                count_next    = PON_LOAD;
                state_next    = ST_POWER_WAIT;
            end
            ST_POWER_WAIT: begin
                if (count_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = count_reg - CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    lcd_rs_next   = cmd_rs;
                    wait_next     = is_clear_cmd ? CLEAR_LOAD : CMD_LOAD;
                    via_cs_next   = 1'b1;
                    via_rs_next   = REG_ORB;
                    via_data_next = cmd_byte;
                    state_next    = ST_SET_CTRL;
                end else begin
                    ready_next = 1'b1;
                end
            end
            ST_SET_CTRL: begin
                via_cs_next   = 1'b1;
                via_rs_next   = REG_ORA;
                via_data_next = port_a_ctrl(1'b0, lcd_rs_reg);
                state_next    = ST_E_HIGH;
            end
            ST_E_HIGH: begin
                via_cs_next   = 1'b1;
                via_rs_next   = REG_ORA;
                via_data_next = port_a_ctrl(1'b1, lcd_rs_reg);
                count_next    = HOLD_LOAD;
                state_next    = ST_E_HOLD;
            end
            ST_E_HOLD: begin
                if (count_reg == '0) begin
                    state_next = ST_E_LOW;
                end else begin
                    count_next = count_reg - CNT_ONE;
                end
            end
            ST_E_LOW: begin
                via_cs_next   = 1'b1;
                via_rs_next   = REG_ORA;
                via_data_next = port_a_ctrl(1'b0, lcd_rs_reg);
                count_next    = wait_reg;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = count_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_INIT_DDRB;
            end
        endcase

        busy_next = !ready_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_INIT_DDRB;
            count_reg    <= '0;
            wait_reg     <= '0;
            lcd_rs_reg   <= 1'b0;
            via_cs_reg   <= 1'b0;
            via_rs_reg   <= 4'd0;
            via_data_reg <= 8'h00;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            wait_reg     <= wait_next;
            lcd_rs_reg   <= lcd_rs_next;
            via_cs_reg   <= via_cs_next;
            via_rs_reg   <= via_rs_next;
            via_data_reg <= via_data_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
        end
    end

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign via_cs    = via_cs_reg;
    assign via_rs    = via_rs_reg;
    assign via_data  = via_data_reg;

endmodule

// File: tb/tb_via_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_via_lcd_sequencer
//
// Directed bench for via_lcd_sequencer with short timing parameters. A simple
// interface_adapter model captures register writes into ORB/ORA/DDRB/DDRA.
// Every expected adapter write (cycle, register, value) is queued when the
// stimulus is driven and popped by a monitor whenever via_cs is seen high.
// -----------------------------------------------------------------------------
module tb_via_lcd_sequencer;

    localparam int H_CYC   = 2;
    localparam int CMD_W   = 5;
    localparam int CLR_W   = 20;
    localparam int PON_W   = 10;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  rs;
        logic [7:0]  data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_rs;
    logic       busy;
    logic       via_cs;
    logic [3:0] via_rs;
    logic [7:0] via_data;

    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];

    // Adapter model registers.
    logic [7:0] orb_reg, ora_reg, ddrb_reg, ddra_reg;
    logic [7:0] port_a, port_b;

    via_lcd_sequencer #(
        .E_HOLD_CYCLES    (H_CYC),
        .CMD_WAIT_CYCLES  (CMD_W),
        .CLEAR_WAIT_CYCLES(CLR_W),
        .POWERON_CYCLES   (PON_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_byte (cmd_byte),
        .cmd_rs   (cmd_rs),
        .busy     (busy),
        .via_cs   (via_cs),
        .via_rs   (via_rs),
        .via_data (via_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(posedge clk) begin
        if (reset) begin
            orb_reg  <= 8'h00;
            ora_reg  <= 8'h00;
            ddrb_reg <= 8'h00;
            ddra_reg <= 8'h00;
        end else if (via_cs) begin
            case (via_rs)
                4'd0: orb_reg  <= via_data;
                4'd1: ora_reg  <= via_data;
                4'd2: ddrb_reg <= via_data;
                4'd3: ddra_reg <= via_data;
                default: ;
            endcase
        end
    end

    assign port_a = ora_reg & ddra_reg;
    assign port_b = orb_reg & ddrb_reg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] c, input logic [3:0] r, input logic [7:0] d);
        wr_t w;
        w.cyc  = c;
        w.rs   = r;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Expected adapter writes for a command accepted in cycle a.
    task automatic push_cmd(input logic [31:0] a, input logic [7:0] b, input logic r);
        logic [7:0] ctrl;
        ctrl = r ? 8'h20 : 8'h00;
        push_wr(a + 32'd1, 4'd0, b);
        push_wr(a + 32'd2, 4'd1, ctrl);
        push_wr(a + 32'd3, 4'd1, ctrl | 8'h80);
        push_wr(a + 32'd4 + 32'(H_CYC), 4'd1, ctrl);
    endtask

    task automatic push_init(input logic [31:0] base);
        push_wr(base + 32'd1, 4'd2, 8'hFF);
        push_wr(base + 32'd2, 4'd3, 8'hE0);
        push_wr(base + 32'd3, 4'd1, 8'h00);
    endtask

    // Called at a negedge; returns at the first negedge where cmd_ready is high.
    task automatic wait_ready(input int budget, output logic [31:0] at_cyc);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) check("ready_timeout", 64'(cmd_ready), 64'(1));
        at_cyc = cyc;
    endtask

    // Called at a negedge with cmd_ready high; the accept happens this cycle.
    task automatic do_cmd(input logic [7:0] b, input logic r, output logic [31:0] acc);
        acc       = cyc;
        push_cmd(acc, b, r);
        cmd_byte  = b;
        cmd_rs    = r;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("ready_drop", 64'(cmd_ready), 64'(0));
        check("busy_after_accept", 64'(busy), 64'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_cs", 64'(via_cs), 64'(0));
        check("rst_rs", 64'(via_rs), 64'(0));
        check("rst_data", 64'(via_data), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (via_cs === 1'b1) begin
            wr_t got;
            wr_t exp;
            got.cyc  = cyc;
            got.rs   = via_rs;
            got.data = via_data;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else                  exp = '1;
            check("adapter_write", 64'(got), 64'(exp));
            if (via_rs == 4'd1) check("rw_low", 64'(via_data[6]), 64'(0));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Latency table: byte, rs, expected accept-to-ready spacing.
    logic [7:0]  t_byte [5] = '{8'h00, 8'h02, 8'h03, 8'h01, 8'h7A};
    logic        t_rs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int          t_lat  [5] = '{12, 27, 12, 12, 12};

    initial begin
        logic [31:0] base, acc, acc2, r;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        cmd_rs    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();

        // 1: power-up sequence.
        base = cyc;
        push_init(base);
        reset = 1'b0;
        @(negedge clk);
        wait_ready(60, r);
        check("ready_rise_cycle", 64'(r - base), 64'(14));
        check("ddrb", 64'(ddrb_reg), 64'(8'hFF));
        check("ddra", 64'(ddra_reg), 64'(8'hE0));
        check("port_a_init", 64'(port_a), 64'(8'h00));
        check("busy_idle", 64'(busy), 64'(0));
        check("init_writes_done", 64'(exp_q.size()), 64'(0));

        // 2: character 'A'.
        do_cmd(8'h41, 1'b1, acc);
        wait_ready(100, r);
        check("lat_char", 64'(r - acc), 64'(12));
        check("port_b_41", 64'(port_b), 64'(8'h41));
        check("port_a_char", 64'(port_a), 64'(8'h20));

        // 3: clear display.
        do_cmd(8'h01, 1'b0, acc);
        wait_ready(100, r);
        check("lat_clear", 64'(r - acc), 64'(27));
        check("port_a_instr", 64'(port_a), 64'(8'h00));

        // Wait-length boundaries.
        for (int i = 0; i < 5; i++) begin
            do_cmd(t_byte[i], t_rs[i], acc);
            wait_ready(100, r);
            check("lat_table", 64'(r - acc), 64'(t_lat[i]));
            check("port_b_table", 64'(port_b), 64'(t_byte[i]));
        end

        // 4: back-to-back with cmd_valid held high.
        acc       = cyc;
        push_cmd(acc, 8'h48, 1'b1);
        cmd_byte  = 8'h48;
        cmd_rs    = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("ready_drop_b2b", 64'(cmd_ready), 64'(0));
        cmd_byte = 8'h49;
        wait_ready(100, acc2);
        check("b2b_spacing", 64'(acc2 - acc), 64'(12));
        push_cmd(acc2, 8'h49, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_ready(100, r);
        check("b2b_second_lat", 64'(r - acc2), 64'(12));
        check("port_b_49", 64'(port_b), 64'(8'h49));

        // 5: cmd_valid pulsed during the post-command wait is ignored.
        do_cmd(8'h30, 1'b1, acc);
        repeat (7) @(negedge clk);
        cmd_byte  = 8'hEE;
        cmd_rs    = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("busy_in_wait", 64'(busy), 64'(1));
        check("ready_in_wait", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b0;
        wait_ready(100, r);
        check("lat_after_pulse", 64'(r - acc), 64'(12));
        check("port_b_30", 64'(port_b), 64'(8'h30));
        check("pulse_no_writes", 64'(exp_q.size()), 64'(0));

        // 6: reset while E is held high.
        do_cmd(8'h55, 1'b1, acc);
        repeat (3) @(negedge clk);
        check("port_a_e_high", 64'(port_a), 64'(8'hA0));
        check("e_low_pending", 64'(exp_q.size()), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        exp_q.delete();
        base = cyc;
        push_init(base);
        reset = 1'b0;
        @(negedge clk);
        wait_ready(60, r);
        check("reinit_ready_cycle", 64'(r - base), 64'(14));
        check("reinit_port_a", 64'(port_a), 64'(8'h00));
        check("reinit_ddrb", 64'(ddrb_reg), 64'(8'hFF));
        repeat (5) @(negedge clk);
        check("no_stray_writes", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
